// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Per-bit conditioning of raw slide-switch pins: a 2-FF synchronizer, then a
//   stability counter that accepts a new level only after it has been seen for
//   STABLE_CYCLES consecutive cycles. Emits the clean level vector plus
//   registered one-cycle rise/fall strobes and a combined change strobe.

module switch_debouncer #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] differ;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] fall_nxt;

   // two-stage synchronizer; only sync2 is used downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   // per-bit acceptance decision and the strobes it implies
   always_comb begin
      differ   = '0;
      accept   = '0;
      rise_nxt = '0;
      fall_nxt = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         differ[i]   = (sync2[i] != sw_clean[i]);
         accept[i]   = differ[i] && (cnt[i] == CNT_MAX);
         rise_nxt[i] = accept[i] && sync2[i];
         fall_nxt[i] = accept[i] && !sync2[i];
      end
   end

   // stability counters: clear on agreement, count while differing, clear on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!differ[i] || accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // clean levels and registered one-cycle strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_clean   <= '0;
         sw_rise    <= '0;
         sw_fall    <= '0;
         sw_changed <= 1'b0;
      end else begin
         sw_clean   <= sw_clean ^ accept;
         sw_rise    <= rise_nxt;
         sw_fall    <= fall_nxt;
         sw_changed <= |(rise_nxt | fall_nxt);
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Directed scenarios plus randomized toggling, checked every cycle against a
//   reference model that tracks, per bit, how many consecutive synchronized
//   samples have disagreed with the accepted level.

module tb_switch_debouncer;

   localparam int unsigned W  = 4;
   localparam int unsigned SC = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_clean;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         sw_changed;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0] m_clean;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic         m_changed;
   int           run [W];
   logic [W-1:0] hist [$];

   switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_raw     (sw_raw),
      .sw_clean   (sw_clean),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_clean   = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_changed = 1'b0;
      hist.delete();
      for (int i = 0; i < W; i++) run[i] = 0;
   endtask

   // one clock edge: the level seen downstream is the pin value sampled two edges ago
   task automatic model_edge(input logic [W-1:0] raw);
      logic [W-1:0] seen;
      seen   = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
         if (seen[i] != m_clean[i]) begin
            run[i]++;
            if (run[i] == SC) begin
               m_clean[i] = seen[i];
               if (seen[i]) m_rise[i] = 1'b1;
               else         m_fall[i] = 1'b1;
               run[i] = 0;
            end
         end else begin
            run[i] = 0;
         end
      end
      m_changed = |(m_rise | m_fall);
      hist.push_back(raw);
      if (hist.size() > 2) void'(hist.pop_front());
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".clean"},   32'(sw_clean),   32'(m_clean));
      chk({tag, ".rise"},    32'(sw_rise),    32'(m_rise));
      chk({tag, ".fall"},    32'(sw_fall),    32'(m_fall));
      chk({tag, ".changed"}, 32'(sw_changed), 32'(m_changed));
   endtask

   task automatic step(input logic [W-1:0] raw, input string tag);
      sw_raw = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
      check_model(tag);
   endtask

   // assert reset mid-cycle, hold across a few edges, release at a falling edge
   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk({tag, ".clean0"}, 32'(sw_clean), 32'h0);
      chk({tag, ".strobe0"}, 32'({sw_rise, sw_fall, sw_changed}), 32'h0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_model({tag, ".held"});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] r;

      // 1: reset with all switches up, re-accepted on edge 6 after release
      rst_n  = 1'b1;
      sw_raw = 4'b1111;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst.clean", 32'(sw_clean), 32'h0);
      chk("rst.strobes", 32'({sw_rise, sw_fall, sw_changed}), 32'h0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check_model("rst.held");
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step(4'b1111, "rel");
         chk("rel.early", 32'(sw_clean), 32'h0);
      end
      step(4'b1111, "rel6");
      chk("rel6.clean", 32'(sw_clean), 32'hF);
      chk("rel6.rise", 32'(sw_rise), 32'hF);
      chk("rel6.changed", 32'(sw_changed), 32'h1);
      step(4'b1111, "rel7");
      chk("rel7.rise", 32'(sw_rise), 32'h0);
      chk("rel7.changed", 32'(sw_changed), 32'h0);

      // back to all-down
      repeat (6) step(4'b0000, "down");
      chk("down.clean", 32'(sw_clean), 32'h0);

      // 3: bit0 glitch of two cycles, then stable high
      repeat (2) step(4'b0001, "glitch");
      repeat (3) begin
         step(4'b0000, "glitch.back");
         chk("glitch.nochg", 32'(sw_changed), 32'h0);
      end
      for (int k = 1; k <= 5; k++) begin
         step(4'b0001, "bounce");
         chk("bounce.early", 32'(sw_clean), 32'h0);
         chk("bounce.nostrobe", 32'(sw_changed), 32'h0);
      end
      step(4'b0001, "bounce6");
      chk("bounce6.clean", 32'(sw_clean), 32'h1);
      chk("bounce6.rise", 32'(sw_rise), 32'h1);
      repeat (6) step(4'b0000, "down2");

      // 2: clean step to 0101
      for (int k = 1; k <= 5; k++) begin
         step(4'b0101, "stepup");
         chk("stepup.early", 32'(sw_clean), 32'h0);
      end
      step(4'b0101, "stepup6");
      chk("stepup6.clean", 32'(sw_clean), 32'h5);
      chk("stepup6.rise", 32'(sw_rise), 32'h5);
      chk("stepup6.fall", 32'(sw_fall), 32'h0);
      step(4'b0101, "stepup7");
      chk("stepup7.rise", 32'(sw_rise), 32'h0);

      // 4: all bits change in the same cycle
      repeat (5) step(4'b1010, "multi");
      step(4'b1010, "multi6");
      chk("multi6.rise", 32'(sw_rise), 32'hA);
      chk("multi6.fall", 32'(sw_fall), 32'h5);
      chk("multi6.changed", 32'(sw_changed), 32'h1);
      step(4'b1010, "multi7");
      chk("multi7.changed", 32'(sw_changed), 32'h0);

      // 5: bit3 toggled every 3 cycles never reaches the clean bus
      for (int k = 0; k < 40; k++) begin
         r = ((k / 3) % 2 == 0) ? 4'b0010 : 4'b1010;
         step(r, "subthr");
         chk("subthr.clean", 32'(sw_clean), 32'hA);
         chk("subthr.changed", 32'(sw_changed), 32'h0);
      end
      repeat (6) step(4'b1010, "settle");

      // 6: reset while bit2 has counted to 2
      step(4'b1110, "mid.e0");
      step(4'b1110, "mid.e1");
      step(4'b1110, "mid.e2");
      step(4'b1110, "mid.e3");
      pulse_reset("midrst");
      for (int k = 1; k <= 5; k++) begin
         step(4'b1110, "mid.rel");
         chk("mid.rel.early", 32'(sw_clean), 32'h0);
      end
      step(4'b1110, "mid.rel6");
      chk("mid.rel6.clean", 32'(sw_clean), 32'hE);
      chk("mid.rel6.rise", 32'(sw_rise), 32'hE);

      // randomized toggling with mixed run lengths, one reset in the middle
      r = 4'b1110;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
         end
         step(r, "rand");
         if (k == 200) pulse_reset("randrst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
